// File: rtl/spike_binner.sv
// Spike binner: synchronizes a raw spike line, applies a refractory dead-time and
// reports a saturating spike count per fixed-length bin with a one-cycle strobe.
module spike_binner #(
    parameter int BIN_CYCLES     = 5000000,
    parameter int REFRACT_CYCLES = 100,
    parameter int MAX_COUNT      = 32767
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               spike_in,
    output logic               bin_strobe,
    output logic signed [15:0] bin_count,
    output logic               overflow,
    output logic               spike_event
);
    localparam int TIMER_W   = 24;
    localparam int REFRACT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    localparam logic [TIMER_W-1:0]   TIMER_LAST   = TIMER_W'(BIN_CYCLES - 1);
    localparam logic [REFRACT_W-1:0] REFRACT_LOAD = REFRACT_W'(REFRACT_CYCLES);
    localparam logic [14:0]          ACC_MAX      = 15'(MAX_COUNT);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    function automatic logic [14:0] sat_add(input logic [14:0] a, input logic inc);
        return (inc && (a != ACC_MAX)) ? a + 15'd1 : a;
    endfunction

    function automatic logic sat_hit(input logic [14:0] a, input logic inc);
        return inc && (a == ACC_MAX);
    endfunction

    logic                 s1, s2, s3;
    logic [0:0]           state;
    logic [TIMER_W-1:0]   timer;
    logic [14:0]          acc;
    logic                 sat_flag;
    logic [REFRACT_W-1:0] refract_cnt;
    logic                 raw_edge;
    logic                 counting;
    logic                 accept;

    assign raw_edge = s2 & ~s3;
    assign counting = (state == COUNT) && enable;
    assign accept   = raw_edge && counting && (refract_cnt == '0);

    // spike_event is the registered accept; acc folds it in one cycle later, so an
    // event visible in the terminal cycle still lands in the closing bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            state       <= IDLE;
            timer       <= '0;
            acc         <= '0;
            sat_flag    <= 1'b0;
            refract_cnt <= '0;
            bin_strobe  <= 1'b0;
            bin_count   <= '0;
            overflow    <= 1'b0;
            spike_event <= 1'b0;
        end else begin
            s1          <= spike_in;
            s2          <= s1;
            s3          <= s2;
            bin_strobe  <= 1'b0;
            spike_event <= accept;

            if (!counting) begin
                // Covers both IDLE and a disable in COUNT: the partial bin is dropped.
                state       <= enable ? COUNT : IDLE;
                timer       <= '0;
                acc         <= '0;
                sat_flag    <= 1'b0;
                refract_cnt <= '0;
            end else begin
                if (accept) begin
                    refract_cnt <= REFRACT_LOAD;
                end else if (refract_cnt != '0) begin
                    refract_cnt <= refract_cnt - REFRACT_W'(1);
                end

                if (timer == TIMER_LAST) begin
                    bin_count  <= $signed({1'b0, sat_add(acc, spike_event)});
                    overflow   <= sat_flag | sat_hit(acc, spike_event);
                    bin_strobe <= 1'b1;
                    acc        <= '0;
                    timer      <= '0;
                    sat_flag   <= 1'b0;
                end else begin
                    acc      <= sat_add(acc, spike_event);
                    sat_flag <= sat_flag | sat_hit(acc, spike_event);
                    timer    <= timer + TIMER_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_binner.sv
// Randomized bench for spike_binner against a bin-level reference model that counts
// accepted spikes without limit and saturates only when a bin is reported.
module tb_spike_binner;
    localparam int BIN     = 24;
    localparam int REFRACT = 3;
    localparam int MAXC    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               spike_in;
    logic               bin_strobe;
    logic signed [15:0] bin_count;
    logic               overflow;
    logic               spike_event;

    spike_binner #(
        .BIN_CYCLES    (BIN),
        .REFRACT_CYCLES(REFRACT),
        .MAX_COUNT     (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .bin_strobe (bin_strobe),
        .bin_count  (bin_count),
        .overflow   (overflow),
        .spike_event(spike_event)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: time is an edge index; dead-time is a distance between edges.
    int   edge_n;
    int   running;
    int   pos;
    int   spikes;
    int   last_acc;
    int   ev;
    logic h1, h2, h3;
    int   exp_strobe, exp_count, exp_ovf;

    task automatic model_reset();
        edge_n     = 0;
        running    = 0;
        pos        = 0;
        spikes     = 0;
        last_acc   = -1000;
        ev         = 0;
        h1         = 1'b0;
        h2         = 1'b0;
        h3         = 1'b0;
        exp_strobe = 0;
        exp_count  = 0;
        exp_ovf    = 0;
    endtask

    task automatic model_edge(input logic sp, input logic en);
        int rise;
        int acc_now;
        rise       = (h2 && !h3) ? 1 : 0;
        acc_now    = 0;
        exp_strobe = 0;
        if (running == 0) begin
            if (en) begin
                running = 1;
                pos     = 0;
            end
            spikes   = 0;
            last_acc = -1000;
        end else if (!en) begin
            running  = 0;
            spikes   = 0;
            last_acc = -1000;
        end else begin
            if (rise != 0 && (edge_n - last_acc) > REFRACT) begin
                acc_now  = 1;
                last_acc = edge_n;
            end
            spikes = spikes + ev;
            if (pos == BIN - 1) begin
                exp_count  = (spikes > MAXC) ? MAXC : spikes;
                exp_ovf    = (spikes > MAXC) ? 1 : 0;
                exp_strobe = 1;
                spikes     = 0;
                pos        = 0;
            end else begin
                pos++;
            end
        end
        ev = acc_now;
        h3 = h2;
        h2 = h1;
        h1 = sp;
        edge_n++;
    endtask

    task automatic compare(input string pfx);
        chk({pfx, "bin_strobe"}, int'(bin_strobe), exp_strobe);
        chk({pfx, "bin_count"}, int'(bin_count), exp_count);
        chk({pfx, "overflow"}, int'(overflow), exp_ovf);
        chk({pfx, "spike_event"}, int'(spike_event), ev);
    endtask

    task automatic step(input logic sp, input logic en);
        spike_in = sp;
        enable   = en;
        @(posedge clk);
        model_edge(sp, en);
        @(negedge clk);
        compare("");
    endtask

    task automatic pulse(input int w, input int gap, input logic en);
        repeat (w) step(1'b1, en);
        repeat (gap) step(1'b0, en);
    endtask

    task automatic wait_pos(input int p);
        int found;
        found = 0;
        for (int i = 0; i < 4 * BIN && found == 0; i++) begin
            if (running != 0 && pos == p) found = 1;
            else step(1'b0, 1'b1);
        end
        if (found == 0) chk("align_timeout", 0, 1);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        spike_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare("reset_");
        rst = 1'b0;

        repeat (3) step(1'b0, 1'b0);
        repeat (3 * BIN) step(1'b0, 1'b1);

        // Rises 3 apart then 8 after the first: the middle one falls in dead-time.
        wait_pos(2);
        pulse(2, 1, 1'b1);
        pulse(2, 3, 1'b1);
        pulse(2, 10, 1'b1);
        repeat (BIN) step(1'b0, 1'b1);

        // spike_event in the terminal cycle, then (next bin) in the strobe cycle.
        wait_pos(BIN - 4);
        pulse(2, 4, 1'b1);
        wait_pos(BIN - 3);
        pulse(2, 4, 1'b1);
        repeat (2 * BIN) step(1'b0, 1'b1);

        wait_pos(0);
        repeat (7) pulse(2, 2, 1'b1);
        repeat (2 * BIN) step(1'b0, 1'b1);

        wait_pos(2);
        pulse(2, 3, 1'b1);
        pulse(2, 3, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        pulse(2, 3, 1'b1);
        repeat (2 * BIN) step(1'b0, 1'b1);

        for (int k = 0; k < 300; k++) begin
            pulse($urandom_range(2, 3), $urandom_range(1, 8), ($urandom_range(0, 19) != 0));
        end
        repeat (BIN + 2) step(1'b0, 1'b1);

        // Asynchronous reset in the middle of a bin with a non-zero held count.
        wait_pos(0);
        repeat (3) pulse(2, 2, 1'b1);
        wait_pos(2);
        pulse(2, 2, 1'b1);
        pulse(2, 2, 1'b1);
        chk("pre_rst_count", int'(bin_count), 3);
        #2 rst = 1'b1;
        spike_in = 1'b0;
        #1;
        model_reset();
        compare("midrst_");
        @(negedge clk);
        rst = 1'b0;

        repeat (2) step(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) pulse(2, $urandom_range(1, 6), 1'b1);
        repeat (BIN + 2) step(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
